// File: rtl/instr_delay_pkg.sv
// Shared types and sizing for the instruction-deferral scheduler.
package instr_delay_pkg;

  localparam int NUM_INSTR     = 4;
  localparam int NUM_DATA_BITS = 64;
  localparam int DEPTH         = 4;
  localparam int MAX_WAIT      = 8;
  localparam int AGE_W         = 4;
  localparam int CNTWIDTH      = $clog2(NUM_INSTR + 1);
  localparam int LANE_W        = $clog2(NUM_INSTR);
  localparam int PTR_W         = $clog2(DEPTH);

  typedef enum logic {
    PASS  = 1'b0,
    FORCE = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [LANE_W-1:0]        lane;
    logic [NUM_DATA_BITS-1:0] data;
    logic [AGE_W-1:0]         ts;
  } deferred_entry_t;

  function automatic logic is_onehot(input logic [NUM_INSTR-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_INSTR; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return (cnt == 1);
  endfunction

  function automatic logic [LANE_W-1:0] onehot_idx(input logic [NUM_INSTR-1:0] v);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_INSTR; i++) begin
      if (v[i]) begin
        idx = idx | LANE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/count_ones.sv
// Population count of a WIDTH-bit vector.
module count_ones #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]               bits_i,
  output logic [$clog2(WIDTH+1)-1:0]     count_o
);
  localparam int CW = $clog2(WIDTH + 1);

  // Sum the set bits.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end
endmodule

// File: rtl/instr_delay_fifo.sv
// Deferred-entry FIFO: storage, pointers, occupancy flags, head/second-entry peek, parked-lane mask.
module instr_delay_fifo
  import instr_delay_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  deferred_entry_t       push_entry_i,
  output deferred_entry_t       head_o,
  output logic [AGE_W-1:0]      next_ts_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  single_o,
  output logic [NUM_INSTR-1:0]  pending_o
);

  deferred_entry_t     mem_q [DEPTH];
  logic [DEPTH-1:0]    vld_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic                push_ok_s;
  logic                pop_ok_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign single_o  = (count_q == (PTR_W+1)'(1));
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign next_ts_o = mem_q[rd_ptr_q + PTR_W'(1)].ts;

  // Storage, valid flags and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Lanes of every occupied slot, decoded straight from storage.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        pending_o = pending_o | (NUM_INSTR'(1) << mem_q[i].lane);
      end else begin
        pending_o = pending_o;
      end
    end
  end
endmodule

// File: rtl/instr_delay_sched.sv
// Instruction deferral scheduler: strips one lane into a FIFO and replays it on idle or forced cycles.
// Optional statistics counters are enabled by defining INSTR_DELAY_SCHED_STATS_EN.
module instr_delay_sched
  import instr_delay_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_INSTR-1:0]      instructions,
  input  logic [NUM_DATA_BITS-1:0]  data_in,
  input  logic                      delay_req,
  input  logic [NUM_INSTR-1:0]      delay_sel,
  output logic                      out_valid,
  output logic [NUM_INSTR-1:0]      out_instr,
  output logic [NUM_DATA_BITS-1:0]  out_data,
  output logic                      out_replay,
  output logic [CNTWIDTH-1:0]       out_count,
  output logic                      delay_drop,
  output logic [NUM_INSTR-1:0]      pending
`ifdef INSTR_DELAY_SCHED_STATS_EN
  ,
  output logic [15:0]               stat_delayed,
  output logic [15:0]               stat_dropped,
  output logic [15:0]               stat_forced
`endif
);

  sched_state_e              state_q, state_d;
  logic [AGE_W-1:0]          now_q;
  deferred_entry_t           head_s, push_entry_s;
  logic [AGE_W-1:0]          next_ts_s, nh_ts_s, nh_age_s;
  logic                      empty_s, full_s, single_s, nh_valid_s;
  logic                      accept_s, legal_s, push_s, pop_s, force_pop_s;
  logic                      out_valid_d, out_replay_d, delay_drop_d;
  logic [NUM_INSTR-1:0]      out_instr_d;
  logic [NUM_DATA_BITS-1:0]  out_data_d;
  logic [CNTWIDTH-1:0]       out_count_d;
  logic                      out_valid_q, out_replay_q, delay_drop_q;
  logic [NUM_INSTR-1:0]      out_instr_q;
  logic [NUM_DATA_BITS-1:0]  out_data_q;
  logic [CNTWIDTH-1:0]       out_count_q;

  instr_delay_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .push_entry_i (push_entry_s),
    .head_o       (head_s),
    .next_ts_o    (next_ts_s),
    .empty_o      (empty_s),
    .full_o       (full_s),
    .single_o     (single_s),
    .pending_o    (pending)
  );

  count_ones #(.WIDTH(NUM_INSTR)) u_cnt (
    .bits_i  (out_instr_d),
    .count_o (out_count_d)
  );

  assign push_entry_s = '{lane: onehot_idx(delay_sel), data: data_in, ts: now_q};

  // Issue selection: forced replay, accepted input, or opportunistic replay.
  always_comb begin
    in_ready     = 1'b0;
    accept_s     = 1'b0;
    legal_s      = 1'b0;
    force_pop_s  = 1'b0;
    pop_s        = 1'b0;
    out_valid_d  = 1'b0;
    out_instr_d  = '0;
    out_data_d   = '0;
    out_replay_d = 1'b0;
    delay_drop_d = 1'b0;
    case (state_q)
      PASS: begin
        in_ready = 1'b1;
        accept_s = in_valid;
        legal_s  = in_valid && delay_req && is_onehot(delay_sel) &&
                   (|(delay_sel & instructions)) && !full_s;
        pop_s    = !in_valid && !empty_s;
      end
      FORCE: begin
        force_pop_s = !empty_s;
        pop_s       = !empty_s;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
    if (pop_s) begin
      out_valid_d  = 1'b1;
      out_instr_d  = NUM_INSTR'(1) << head_s.lane;
      out_data_d   = head_s.data;
      out_replay_d = 1'b1;
    end else if (accept_s) begin
      out_valid_d  = 1'b1;
      out_instr_d  = legal_s ? (instructions & ~delay_sel) : instructions;
      out_data_d   = data_in;
      delay_drop_d = delay_req && !legal_s;
    end else begin
      out_valid_d  = 1'b0;
    end
  end

  assign push_s = legal_s;

  // FORCE is entered for exactly the cycles in which the head is at age MAX_WAIT-1,
  // so the next-cycle head and its age are predicted here.
  always_comb begin
    nh_valid_s = !empty_s;
    nh_ts_s    = head_s.ts;
    if (pop_s) begin
      nh_valid_s = !single_s;
      nh_ts_s    = next_ts_s;
    end else if (push_s && empty_s) begin
      nh_valid_s = 1'b1;
      nh_ts_s    = now_q;
    end else begin
      nh_valid_s = !empty_s;
      nh_ts_s    = head_s.ts;
    end
    nh_age_s = now_q + AGE_W'(1) - nh_ts_s;
    state_d  = (nh_valid_s && (nh_age_s >= AGE_W'(MAX_WAIT - 1))) ? FORCE : PASS;
  end

  // State, timestamp counter and registered issue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PASS;
      now_q        <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_data_q   <= '0;
      out_replay_q <= 1'b0;
      out_count_q  <= '0;
      delay_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      now_q        <= now_q + AGE_W'(1);
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_data_q   <= out_data_d;
      out_replay_q <= out_replay_d;
      out_count_q  <= out_count_d;
      delay_drop_q <= delay_drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_data   = out_data_q;
  assign out_replay = out_replay_q;
  assign out_count  = out_count_q;
  assign delay_drop = delay_drop_q;

`ifdef INSTR_DELAY_SCHED_STATS_EN
  logic [15:0] stat_delayed_q, stat_dropped_q, stat_forced_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_delayed_q <= 16'd0;
      stat_dropped_q <= 16'd0;
      stat_forced_q  <= 16'd0;
    end else begin
      if (push_s && (stat_delayed_q != 16'hFFFF)) stat_delayed_q <= stat_delayed_q + 16'd1;
      if (delay_drop_d && (stat_dropped_q != 16'hFFFF)) stat_dropped_q <= stat_dropped_q + 16'd1;
      if (force_pop_s && (stat_forced_q != 16'hFFFF)) stat_forced_q <= stat_forced_q + 16'd1;
    end
  end

  assign stat_delayed = stat_delayed_q;
  assign stat_dropped = stat_dropped_q;
  assign stat_forced  = stat_forced_q;
`endif

endmodule

// File: tb/tb_instr_delay_sched.sv
// Self-checking bench: queue-based reference model checked every cycle, plus directed literal checks.
module tb_instr_delay_sched;

  localparam int MW  = 8;
  localparam int DEP = 4;

  logic        clk, rst_n, in_valid, in_ready, delay_req;
  logic [3:0]  instructions, delay_sel, out_instr, pending;
  logic [63:0] data_in, out_data;
  logic        out_valid, out_replay, delay_drop;
  logic [2:0]  out_count;
`ifdef INSTR_DELAY_SCHED_STATS_EN
  logic [15:0] stat_delayed, stat_dropped, stat_forced;
`endif

  int checks = 0;
  int errors = 0;

  instr_delay_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instructions (instructions),
    .data_in      (data_in),
    .delay_req    (delay_req),
    .delay_sel    (delay_sel),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_data     (out_data),
    .out_replay   (out_replay),
    .out_count    (out_count),
    .delay_drop   (delay_drop),
    .pending      (pending)
`ifdef INSTR_DELAY_SCHED_STATS_EN
    ,
    .stat_delayed (stat_delayed),
    .stat_dropped (stat_dropped),
    .stat_forced  (stat_forced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: deferred entries remember the absolute cycle they were parked in.
  typedef struct {
    int          lane;
    logic [63:0] data;
    int          c;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  logic        e_valid = 1'b0, e_replay = 1'b0, e_drop = 1'b0;
  logic [3:0]  e_instr = 4'd0;
  logic [63:0] e_data = 64'd0;
  int          n_del = 0, n_drop = 0, n_force = 0;

  function automatic logic model_ready();
    return !(q.size() > 0 && (cyc - q[0].c) >= MW - 1);
  endfunction

  function automatic logic [3:0] model_pending();
    logic [3:0] p;
    p = 4'd0;
    foreach (q[i]) p[q[i].lane] = 1'b1;
    return p;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        cyc = 0; n_del = 0; n_drop = 0; n_force = 0;
        e_valid = 1'b0; e_instr = 4'd0; e_data = 64'd0; e_replay = 1'b0; e_drop = 1'b0;
      end else begin
        logic forced, legal;
        ent_t e;
        forced = !model_ready();
        e_valid = 1'b0; e_instr = 4'd0; e_data = 64'd0; e_replay = 1'b0; e_drop = 1'b0;
        if (forced || (!in_valid && q.size() > 0)) begin
          e = q.pop_front();
          e_valid = 1'b1; e_instr = 4'd0; e_instr[e.lane] = 1'b1;
          e_data = e.data; e_replay = 1'b1;
          if (forced) n_force++;
        end else if (in_valid) begin
          legal = delay_req && ($countones(delay_sel) == 1) &&
                  ((delay_sel & instructions) != 4'd0) && (q.size() < DEP);
          e_valid = 1'b1;
          e_data  = data_in;
          e_instr = legal ? (instructions & ~delay_sel) : instructions;
          e_drop  = delay_req && !legal;
          if (e_drop) n_drop++;
          if (legal) begin
            e.data = data_in; e.c = cyc; e.lane = 0;
            for (int i = 0; i < 4; i++) if (delay_sel[i]) e.lane = i;
            q.push_back(e);
            n_del++;
          end
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_drop", 64'(delay_drop), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
      end else begin
        check("out_valid", 64'(out_valid), 64'(e_valid));
        check("out_instr", 64'(out_instr), 64'(e_instr));
        check("out_data", out_data, e_data);
        check("out_replay", 64'(out_replay), 64'(e_replay));
        check("out_count", 64'(out_count), 64'($countones(e_instr)));
        check("delay_drop", 64'(delay_drop), 64'(e_drop));
        check("pending", 64'(pending), 64'(model_pending()));
        check("in_ready", 64'(in_ready), 64'(model_ready()));
`ifdef INSTR_DELAY_SCHED_STATS_EN
        check("stat_delayed", 64'(stat_delayed), 64'(n_del));
        check("stat_dropped", 64'(stat_dropped), 64'(n_drop));
        check("stat_forced", 64'(stat_forced), 64'(n_force));
`endif
      end
    end
  end

  task automatic drive(input logic iv, input logic [3:0] ins, input logic [63:0] d,
                       input logic dr, input logic [3:0] sel);
    in_valid = iv; instructions = ins; data_in = d; delay_req = dr; delay_sel = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b1; instructions = 4'b0011; data_in = 64'h5; delay_req = 1'b0; delay_sel = 4'd0;
    #1 rst_n = 1'b0;
    // 1: reset with in_valid held
    repeat (3) @(posedge clk);
    #1;
    check("t1_rst_valid", 64'(out_valid), 64'd0);
    check("t1_rst_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 4'b0011, 64'h1111, 1'b0, 4'b0000);
    check("t1_instr", 64'(out_instr), 64'h3);
    check("t1_count", 64'(out_count), 64'd2);

    // 2: defer lane 2, then replay on idle
    drive(1'b1, 4'b0110, 64'hAAAA_0000_AAAA_0001, 1'b1, 4'b0100);
    check("t2_instr", 64'(out_instr), 64'h2);
    check("t2_data", out_data, 64'hAAAA_0000_AAAA_0001);
    check("t2_pending", 64'(pending), 64'h4);
    drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);
    check("t2_rinstr", 64'(out_instr), 64'h4);
    check("t2_rdata", out_data, 64'hAAAA_0000_AAAA_0001);
    check("t2_replay", 64'(out_replay), 64'd1);
    drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);

    // 3: forced replay with input held busy
    drive(1'b1, 4'b0001, 64'hBBBB, 1'b1, 4'b0001);
    for (int k = 1; k <= 7; k++) begin
      check("t3_ready", 64'(in_ready), (k < 7) ? 64'd1 : 64'd0);
      drive(1'b1, 4'b0010, 64'hCCCC, 1'b0, 4'b0000);
    end
    check("t3_replay", 64'(out_replay), 64'd1);
    check("t3_rinstr", 64'(out_instr), 64'h1);
    check("t3_rdata", out_data, 64'hBBBB);
    check("t3_ready_after", 64'(in_ready), 64'd1);
    drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);

    // 4: DEPTH+1 consecutive delays
    drive(1'b1, 4'b1111, 64'hD1, 1'b1, 4'b0001);
    drive(1'b1, 4'b1111, 64'hD2, 1'b1, 4'b0010);
    drive(1'b1, 4'b1111, 64'hD3, 1'b1, 4'b0100);
    drive(1'b1, 4'b1111, 64'hD4, 1'b1, 4'b1000);
    check("t4_instr4", 64'(out_instr), 64'h7);
    drive(1'b1, 4'b1111, 64'hD5, 1'b1, 4'b0001);
    check("t4_drop", 64'(delay_drop), 64'd1);
    check("t4_instr5", 64'(out_instr), 64'hF);
    check("t4_pending", 64'(pending), 64'hF);
    repeat (4) drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);
    check("t4_drained", 64'(pending), 64'h0);

    // 5: illegal selects
    drive(1'b1, 4'b0001, 64'hE1, 1'b1, 4'b0011);
    check("t5_drop_multi", 64'(delay_drop), 64'd1);
    check("t5_pass_multi", 64'(out_instr), 64'h1);
    drive(1'b1, 4'b0001, 64'hE2, 1'b1, 4'b1000);
    check("t5_drop_absent", 64'(delay_drop), 64'd1);
    check("t5_pending", 64'(pending), 64'h0);
    drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);
    check("t5_idle", 64'(out_valid), 64'd0);

    // 6: reset discards parked entries
    drive(1'b1, 4'b0111, 64'hF1, 1'b1, 4'b0001);
    drive(1'b1, 4'b0111, 64'hF2, 1'b1, 4'b0010);
    drive(1'b1, 4'b0111, 64'hF3, 1'b1, 4'b0100);
    check("t6_pending", 64'(pending), 64'h7);
    in_valid = 1'b0; delay_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pending", 64'(pending), 64'h0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);
      check("t6_no_replay", 64'(out_valid), 64'd0);
    end
    drive(1'b1, 4'b1010, 64'h77, 1'b1, 4'b1000);
    drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);
    drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
